// File: rtl/grf_if.sv
// grf_if: register-file bus (pc, ra1/ra2, rd1/rd2, rd*_busy, we0/wa0/wd0, we1/wa1/wd1/wpc1, issue/issue_addr, trace_*)
interface grf_if #(parameter int DATA_W = 32, parameter int ADDR_W = 5);
  logic [31:0]       pc;
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              rd1_busy;
  logic              rd2_busy;
  logic              we0;
  logic [ADDR_W-1:0] wa0;
  logic [DATA_W-1:0] wd0;
  logic              we1;
  logic [ADDR_W-1:0] wa1;
  logic [DATA_W-1:0] wd1;
  logic [31:0]       wpc1;
  logic              issue;
  logic [ADDR_W-1:0] issue_addr;
  logic              trace_valid;
  logic [31:0]       trace_pc;
  logic [ADDR_W-1:0] trace_addr;
  logic [DATA_W-1:0] trace_data;
  modport master (
    output pc, ra1, ra2, we0, wa0, wd0, we1, wa1, wd1, wpc1, issue, issue_addr,
    input  rd1, rd2, rd1_busy, rd2_busy, trace_valid, trace_pc, trace_addr, trace_data
  );
  modport slave (
    input  pc, ra1, ra2, we0, wa0, wd0, we1, wa1, wd1, wpc1, issue, issue_addr,
    output rd1, rd2, rd1_busy, rd2_busy, trace_valid, trace_pc, trace_addr, trace_data
  );
endinterface

// File: rtl/grf_multi.sv
// grf_multi: 2-write-port register file with bypass, busy scoreboard and registered trace (ports: clk, reset active-low sync, bus grf_if.slave)
module grf_multi #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input logic  clk,
  input logic  reset,
  grf_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic              trace_valid_q, trace_valid_d;
  logic [31:0]       trace_pc_q, trace_pc_d;
  logic [ADDR_W-1:0] trace_addr_q, trace_addr_d;
  logic [DATA_W-1:0] trace_data_q, trace_data_d;
  logic              c0, c1;
  always_comb begin
    c1 = bus.we1 && !(ZERO_REG && bus.wa1 == '0);
    c0 = bus.we0 && !(ZERO_REG && bus.wa0 == '0) && !(c1 && bus.wa0 == bus.wa1);
    regs_d = regs_q;
    if (c0) regs_d[bus.wa0] = bus.wd0;
    if (c1) regs_d[bus.wa1] = bus.wd1;
    busy_d = busy_q;
    if (bus.we1) busy_d[bus.wa1] = 1'b0;
    if (bus.issue && !(ZERO_REG && bus.issue_addr == '0)) busy_d[bus.issue_addr] = 1'b1;
    trace_valid_d = c0 || c1;
    trace_pc_d    = c1 ? bus.wpc1 : c0 ? bus.pc  : trace_pc_q;
    trace_addr_d  = c1 ? bus.wa1  : c0 ? bus.wa0 : trace_addr_q;
    trace_data_d  = c1 ? bus.wd1  : c0 ? bus.wd0 : trace_data_q;
  end
  always_comb begin
    bus.rd1 = (ZERO_REG && bus.ra1 == '0) ? '0 :
              (BYPASS && bus.we1 && bus.wa1 == bus.ra1) ? bus.wd1 :
              (BYPASS && bus.we0 && bus.wa0 == bus.ra1) ? bus.wd0 : regs_q[bus.ra1];
    bus.rd2 = (ZERO_REG && bus.ra2 == '0) ? '0 :
              (BYPASS && bus.we1 && bus.wa1 == bus.ra2) ? bus.wd1 :
              (BYPASS && bus.we0 && bus.wa0 == bus.ra2) ? bus.wd0 : regs_q[bus.ra2];
    bus.rd1_busy    = busy_q[bus.ra1];
    bus.rd2_busy    = busy_q[bus.ra2];
    bus.trace_valid = trace_valid_q;
    bus.trace_pc    = trace_pc_q;
    bus.trace_addr  = trace_addr_q;
    bus.trace_data  = trace_data_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      regs_q        <= '{default: '0};
      busy_q        <= '0;
      trace_valid_q <= 1'b0;
      trace_pc_q    <= '0;
      trace_addr_q  <= '0;
      trace_data_q  <= '0;
    end else begin
      regs_q        <= regs_d;
      busy_q        <= busy_d;
      trace_valid_q <= trace_valid_d;
      trace_pc_q    <= trace_pc_d;
      trace_addr_q  <= trace_addr_d;
      trace_data_q  <= trace_data_d;
    end
  end
endmodule

// File: tb/tb_grf_multi.sv
// tb_grf_multi: directed and randomized checks of grf_multi against a behavioural register-file model
module tb_grf_multi;
  logic clk = 0;
  logic reset = 1;
  int errors = 0;
  int checks = 0;
  logic [31:0] mem [32];
  bit          busy [32];
  logic        m_tv;
  logic [31:0] m_tp, m_td;
  logic [4:0]  m_ta;
  grf_if #(.DATA_W(32), .ADDR_W(5)) b();
  grf_multi #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (.clk(clk), .reset(reset), .bus(b));
  always #5 clk = ~clk;
  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 0) return 0;
    if (b.we1 && b.wa1 == a) return b.wd1;
    if (b.we0 && b.wa0 == a) return b.wd0;
    return mem[a];
  endfunction
  task automatic idle();
    b.we0 = 0; b.we1 = 0; b.issue = 0;
    b.wa0 = 0; b.wa1 = 0; b.wd0 = 0; b.wd1 = 0;
    b.pc = 0; b.wpc1 = 0; b.issue_addr = 0;
  endtask
  task automatic tick();
    if (!reset) begin
      foreach (mem[i]) begin mem[i] = 0; busy[i] = 0; end
      m_tv = 0; m_tp = 0; m_ta = 0; m_td = 0;
    end else begin
      m_tv = 0;
      if (b.we0 && b.wa0 != 0) begin mem[b.wa0] = b.wd0; m_tv = 1; m_tp = b.pc; m_ta = b.wa0; m_td = b.wd0; end
      if (b.we1 && b.wa1 != 0) begin mem[b.wa1] = b.wd1; m_tv = 1; m_tp = b.wpc1; m_ta = b.wa1; m_td = b.wd1; end
      if (b.we1) busy[b.wa1] = 0;
      if (b.issue && b.issue_addr != 0) busy[b.issue_addr] = 1;
    end
    @(posedge clk); #1;
  endtask
  task automatic test_reset();
    idle(); b.ra1 = 0; b.ra2 = 0;
    reset = 0; tick(); reset = 1;
    b.we0 = 1; b.wa0 = 5; b.wd0 = 32'h1234; tick(); idle();
    b.issue = 1; b.issue_addr = 6; tick(); idle();
    reset = 0; b.we1 = 1; b.wa1 = 8; b.wd1 = 32'h77; tick(); tick(); reset = 1; idle();
    b.ra1 = 5; b.ra2 = 8; #1;
    checks++; if (b.rd1 !== 0) begin errors++; $display("FAIL reset_r5 got=%h exp=0", b.rd1); end
    checks++; if (b.rd2 !== 0) begin errors++; $display("FAIL reset_r8 got=%h exp=0", b.rd2); end
    for (int i = 0; i < 32; i++) begin
      b.ra1 = 5'(i); #1;
      checks++; if (b.rd1_busy !== 0) begin errors++; $display("FAIL reset_busy[%0d] got=%b exp=0", i, b.rd1_busy); end
    end
    checks++;
    if ({b.trace_valid, b.trace_pc, b.trace_addr, b.trace_data} !== '0) begin
      errors++; $display("FAIL reset_trace got v=%b pc=%h a=%0d d=%h exp all 0", b.trace_valid, b.trace_pc, b.trace_addr, b.trace_data);
    end
  endtask
  task automatic test_bypass();
    b.we0 = 1; b.wa0 = 3; b.wd0 = 32'hDEADBEEF; b.pc = 32'h400; b.ra1 = 3; #1;
    checks++; if (b.rd1 !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_rd1 got=%h exp=deadbeef", b.rd1); end
    tick(); idle(); #1;
    checks++;
    if ({b.trace_valid, b.trace_pc, b.trace_addr, b.trace_data} !== {1'b1, 32'h400, 5'd3, 32'hDEADBEEF}) begin
      errors++; $display("FAIL bypass_trace got v=%b pc=%h a=%0d d=%h exp v=1 pc=400 a=3 d=deadbeef", b.trace_valid, b.trace_pc, b.trace_addr, b.trace_data);
    end
    checks++; if (b.rd1 !== 32'hDEADBEEF) begin errors++; $display("FAIL array_rd1 got=%h exp=deadbeef", b.rd1); end
    tick(); #1;
    checks++; if (b.trace_valid !== 0 || b.trace_pc !== 32'h400 || b.trace_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL trace_hold got v=%b pc=%h d=%h exp v=0 pc=400 d=deadbeef", b.trace_valid, b.trace_pc, b.trace_data);
    end
  endtask
  task automatic test_collision();
    b.we0 = 1; b.wa0 = 7; b.wd0 = 32'h11; b.pc = 32'h500;
    b.we1 = 1; b.wa1 = 7; b.wd1 = 32'h22; b.wpc1 = 32'h600; b.ra2 = 7; #1;
    checks++; if (b.rd2 !== 32'h22) begin errors++; $display("FAIL coll_bypass got=%h exp=22", b.rd2); end
    tick(); idle(); #1;
    checks++; if (b.rd2 !== 32'h22) begin errors++; $display("FAIL coll_r7 got=%h exp=22", b.rd2); end
    checks++;
    if ({b.trace_valid, b.trace_pc, b.trace_addr, b.trace_data} !== {1'b1, 32'h600, 5'd7, 32'h22}) begin
      errors++; $display("FAIL coll_trace got v=%b pc=%h a=%0d d=%h exp v=1 pc=600 a=7 d=22", b.trace_valid, b.trace_pc, b.trace_addr, b.trace_data);
    end
  endtask
  task automatic test_busy();
    b.issue = 1; b.issue_addr = 9; b.ra1 = 9; #1;
    checks++; if (b.rd1_busy !== 0) begin errors++; $display("FAIL busy_pre got=%b exp=0", b.rd1_busy); end
    tick(); idle(); tick(); #1;
    checks++; if (b.rd1_busy !== 1) begin errors++; $display("FAIL busy_set got=%b exp=1", b.rd1_busy); end
    b.we1 = 1; b.wa1 = 9; b.wd1 = 32'h55; tick(); idle(); #1;
    checks++; if (b.rd1_busy !== 0 || b.rd1 !== 32'h55) begin errors++; $display("FAIL busy_clr got busy=%b rd1=%h exp busy=0 rd1=55", b.rd1_busy, b.rd1); end
    b.issue = 1; b.issue_addr = 9; b.we1 = 1; b.wa1 = 9; b.wd1 = 32'h66; tick(); idle(); #1;
    checks++; if (b.rd1_busy !== 1 || b.rd1 !== 32'h66) begin errors++; $display("FAIL busy_setwins got busy=%b rd1=%h exp busy=1 rd1=66", b.rd1_busy, b.rd1); end
    b.we0 = 1; b.wa0 = 9; b.wd0 = 32'h67; tick(); idle(); #1;
    checks++; if (b.rd1_busy !== 1) begin errors++; $display("FAIL busy_port0 got=%b exp=1", b.rd1_busy); end
    b.we1 = 1; b.wa1 = 9; b.wd1 = 32'h68; tick(); idle();
  endtask
  task automatic test_zero();
    b.we0 = 1; b.wa0 = 0; b.wd0 = 32'hFFFFFFFF; b.issue = 1; b.issue_addr = 0; b.ra1 = 0; #1;
    checks++; if (b.rd1 !== 0) begin errors++; $display("FAIL zero_bypass got=%h exp=0", b.rd1); end
    tick(); idle(); #1;
    checks++; if (b.rd1 !== 0 || b.rd1_busy !== 0 || b.trace_valid !== 0) begin
      errors++; $display("FAIL zero_reg got rd1=%h busy=%b tv=%b exp 0 0 0", b.rd1, b.rd1_busy, b.trace_valid);
    end
  endtask
  task automatic test_reset_busy();
    b.issue = 1; b.issue_addr = 4; tick(); idle(); b.ra1 = 4; #1;
    checks++; if (b.rd1_busy !== 1) begin errors++; $display("FAIL rb_set got=%b exp=1", b.rd1_busy); end
    reset = 0; tick(); reset = 1; #1;
    checks++; if (b.rd1_busy !== 0) begin errors++; $display("FAIL rb_clear got=%b exp=0", b.rd1_busy); end
    b.we1 = 1; b.wa1 = 4; b.wd1 = 32'h99; b.wpc1 = 32'h700; tick(); idle(); #1;
    checks++; if (b.rd1 !== 32'h99 || b.trace_valid !== 1 || b.trace_pc !== 32'h700) begin
      errors++; $display("FAIL rb_write got rd1=%h tv=%b pc=%h exp 99 1 700", b.rd1, b.trace_valid, b.trace_pc);
    end
  endtask
  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 39) != 0);
      b.we0 = 1'($urandom); b.wa0 = 5'($urandom_range(0, 7)); b.wd0 = $urandom; b.pc = $urandom;
      b.we1 = 1'($urandom); b.wa1 = 5'($urandom_range(0, 7)); b.wd1 = $urandom; b.wpc1 = $urandom;
      b.issue = 1'($urandom); b.issue_addr = 5'($urandom_range(0, 7));
      b.ra1 = 5'($urandom_range(0, 8)); b.ra2 = 5'($urandom_range(0, 8)); #1;
      checks++;
      if (b.rd1 !== exp_rd(b.ra1) || b.rd2 !== exp_rd(b.ra2) || b.rd1_busy !== busy[b.ra1] || b.rd2_busy !== busy[b.ra2]) begin
        errors++; $display("FAIL rand_read[%0d] got rd1=%h rd2=%h b1=%b b2=%b exp rd1=%h rd2=%h b1=%b b2=%b", n,
          b.rd1, b.rd2, b.rd1_busy, b.rd2_busy, exp_rd(b.ra1), exp_rd(b.ra2), busy[b.ra1], busy[b.ra2]);
      end
      tick();
      checks++;
      if (b.trace_valid !== m_tv || (m_tv && {b.trace_pc, b.trace_addr, b.trace_data} !== {m_tp, m_ta, m_td})) begin
        errors++; $display("FAIL rand_trace[%0d] got v=%b pc=%h a=%0d d=%h exp v=%b pc=%h a=%0d d=%h", n,
          b.trace_valid, b.trace_pc, b.trace_addr, b.trace_data, m_tv, m_tp, m_ta, m_td);
      end
    end
    reset = 1; idle();
  endtask
  initial begin
    foreach (mem[i]) begin mem[i] = 0; busy[i] = 0; end
    m_tv = 0; m_tp = 0; m_ta = 0; m_td = 0;
    idle(); b.ra1 = 0; b.ra2 = 0;
    @(posedge clk); #1;
    test_reset();
    test_bypass();
    test_collision();
    test_busy();
    test_zero();
    test_reset_busy();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/grf_multi.md
Name: grf_multi

Overview:
- Parametrised general register file, successor to the single-cycle GRF.
- Generalised width and depth, plus:
  - two write ports: port 0 for ALU/load writeback, port 1 for multi-cycle unit writeback;
  - optional write-to-read bypass;
  - per-register busy scoreboard for multi-cycle ops;
  - registered writeback trace interface.
- Sits in the decode stage; feeds operand and hazard logic.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and is never busy.
- BYPASS, 1, when 1 a read of an address written this cycle returns the incoming write data.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low; reset==0 at a rising clk edge clears state.
- pc  in  32  PC of the instruction writing via port 0, for trace.
- ra1  in  ADDR_W  read address A.
- ra2  in  ADDR_W  read address B.
- rd1  out  DATA_W  read data A, combinational.
- rd2  out  DATA_W  read data B, combinational.
- rd1_busy  out  1  register ra1 has a pending multi-cycle write.
- rd2_busy  out  1  register ra2 has a pending multi-cycle write.
- we0  in  1  write enable, port 0.
- wa0  in  ADDR_W  write address, port 0.
- wd0  in  DATA_W  write data, port 0.
- we1  in  1  write enable, port 1 (multi-cycle writeback).
- wa1  in  ADDR_W  write address, port 1.
- wd1  in  DATA_W  write data, port 1.
- wpc1  in  32  PC associated with the port 1 write.
- issue  in  1  mark issue_addr busy (multi-cycle op dispatched).
- issue_addr  in  ADDR_W  destination register of the dispatched op.
- trace_valid  out  1  a register write committed at the last edge.
- trace_pc  out  32  PC of the committed write.
- trace_addr  out  ADDR_W  register written.
- trace_data  out  DATA_W  value written.

Behaviour:
- Reset (reset==0 at posedge):
  - all registers = 0, all busy bits = 0;
  - trace_valid=0, trace_pc=0, trace_addr=0, trace_data=0;
  - all write and issue inputs ignored that cycle.
- Reset has priority over everything. Reset mid-operation discards pending busy state; a later we1 to that address still writes normally.
- Read:
  - rd1/rd2 are combinational from the array.
  - With ZERO_REG=1, address 0 returns 0.
  - With BYPASS=1, if we1 and wa1==ra1, rd1=wd1; else if we0 and wa0==ra1, rd1=wd0; else array. Same rule for rd2.
  - Bypass never applies to address 0 when ZERO_REG=1.
  - rd1_busy = busy[ra1], from registered state only (not bypassed).
- Write, at posedge with reset==1:
  - we0 writes wd0 to wa0; we1 writes wd1 to wa1.
  - If both target the same address, port 1 wins and port 0's write is dropped.
  - Writes to address 0 are suppressed when ZERO_REG=1.
- Busy scoreboard, per register, at posedge:
  - we1 to addr clears busy[addr].
  - issue to addr sets busy[addr].
  - issue and we1 to the same address in the same cycle: set wins, so busy stays 1 (new op supersedes).
  - issue to address 0 has no effect when ZERO_REG=1.
  - Port 0 writes do not affect busy.
- Trace (registered, 1-cycle latency after the write edge):
  - Exactly one committed write per cycle is reported; if both ports commit, port 1 is reported and port 0 is not.
  - trace_pc = wpc1 or pc accordingly.
  - Suppressed writes (address 0) produce trace_valid=0.
  - trace_valid deasserts in any cycle with no committed write; the other trace fields hold their last values.
- No write latency beyond the edge: a value written at edge N is readable from the array after edge N.

Test Plan:
- Assert reset=0 for 2 cycles after preloading r5=0x1234 -> rd1 with ra1=5 reads 0, all busy 0, trace_valid=0.
- we0=1, wa0=3, wd0=0xDEADBEEF, ra1=3, BYPASS=1 -> rd1=0xDEADBEEF in the same cycle; next cycle trace_valid=1, trace_addr=3, trace_data=0xDEADBEEF, trace_pc=pc.
- we0 and we1 both to addr 7 (wd0=0x11, wd1=0x22) -> r7=0x22 afterwards, and the trace reports port 1 with wpc1.
- issue=1, issue_addr=9 -> rd1_busy=1 for ra1=9 until we1 to wa1=9 with wd1=0x55, then busy=0 and rd1=0x55. Issue and we1 to 9 in the same cycle -> busy stays 1.
- we0 to addr 0 with 0xFFFFFFFF, plus issue to 0 (ZERO_REG=1) -> rd1=0, busy 0, trace_valid=0.
- issue to addr 4, then reset=0 for one cycle -> busy[4]=0 after the edge. Subsequent we1 to 4 with 0x99 -> r4=0x99.
